// File: rtl/fp_mant_align_pipe_pkg.sv
// rtl/fp_mant_align_pipe_pkg.sv - shared FP adder defaults: field widths, ext width helper
package fp_mant_align_pipe_pkg;

  // Default operand geometry shared by all FP adder stages (single precision)
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_GRD_W = 3;

  // Extended mantissa width: hidden bit + stored fraction + guard bits
  function automatic int ext_width(input int man_w, input int grd_w);
    return man_w + 1 + grd_w;
  endfunction

  localparam int FP_EXT_W = ext_width(FP_MAN_W, FP_GRD_W);

endpackage

// File: rtl/fp_mant_align_pipe_if.sv
// rtl/fp_mant_align_pipe_if.sv - operand-in / aligned-out handshake bundle for the align stage
interface fp_mant_align_pipe_if
  import fp_mant_align_pipe_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int GRD_W = FP_GRD_W
);
  localparam int W = ext_width(MAN_W, GRD_W);

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_man;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] b_man;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] big_exp;
  logic [W-1:0]     big_man;
  logic [W-1:0]     small_man;
  logic             swap;

  // Producer of operands / consumer of aligned results
  modport master (
    output in_valid, a_exp, a_man, b_exp, b_man, out_ready,
    input  in_ready, out_valid, big_exp, big_man, small_man, swap
  );

  // The alignment pipeline itself
  modport slave (
    input  in_valid, a_exp, a_man, b_exp, b_man, out_ready,
    output in_ready, out_valid, big_exp, big_man, small_man, swap
  );

endinterface

// File: rtl/fp_mant_align_pipe_rshift.sv
// rtl/fp_mant_align_pipe_rshift.sv - barrel right shift with optional sticky OR (FP_ALIGN_STICKY_EN)
module fp_rshift_sticky
  import fp_mant_align_pipe_pkg::*;
#(
  parameter int W     = FP_EXT_W,
  parameter int EXP_W = FP_EXP_W
) (
  input  logic [W-1:0]     din,
  input  logic [EXP_W-1:0] shamt,
  output logic [W-1:0]     dout
);

  // Logical shift; amounts of W or more naturally yield zero
  logic [W-1:0] shifted;
  assign shifted = din >> shamt;

`ifdef FP_ALIGN_STICKY_EN
  // Mask of the bit positions pushed out below the LSB; all ones when shamt >= W
  logic [W-1:0] lost_mask;
  logic         sticky;
  assign lost_mask = ~({W{1'b1}} << shamt);
  assign sticky    = |(din & lost_mask);
  assign dout      = {shifted[W-1:1], shifted[0] | sticky};
`else
  assign dout = shifted;
`endif

endmodule

// File: rtl/fp_mant_align_pipe.sv
// rtl/fp_mant_align_pipe.sv - 2-stage operand order + mantissa align (sticky via FP_ALIGN_STICKY_EN)
module fp_mant_align_pipe
  import fp_mant_align_pipe_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int GRD_W = FP_GRD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_mant_align_pipe_if.slave  io
);

  localparam int W = ext_width(MAN_W, GRD_W);

  // Stage registers
  logic             s1_valid;
  logic [W-1:0]     s1_big_man;
  logic [W-1:0]     s1_small_man;
  logic [EXP_W-1:0] s1_big_exp;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_swap;

  logic             s2_valid;
  logic [W-1:0]     s2_big_man;
  logic [W-1:0]     s2_small_man;
  logic [EXP_W-1:0] s2_big_exp;
  logic             s2_swap;

  // Handshake: each stage loads when empty or when its occupant leaves this cycle
  logic s1_adv;
  logic in_fire;
  assign s1_adv      = s1_valid & (~s2_valid | io.out_ready);
  assign io.in_ready = ~s1_valid | s1_adv;
  assign in_fire     = io.in_valid & io.in_ready;

  // Compare stage signals
  logic             a_hid, b_hid;
  logic [EXP_W-1:0] a_eff, b_eff;
  logic [W-1:0]     a_ext, b_ext;
  logic             cmp_swap;
  logic [W-1:0]     cmp_big_man, cmp_small_man;
  logic [EXP_W-1:0] cmp_big_exp, cmp_diff;

  // Order operands by raw exponent then fraction; denormals act as exponent 1 for the shift
  always_comb begin
    a_hid    = |io.a_exp;
    b_hid    = |io.b_exp;
    a_eff    = a_hid ? io.a_exp : EXP_W'(1);
    b_eff    = b_hid ? io.b_exp : EXP_W'(1);
    a_ext    = {a_hid, io.a_man, {GRD_W{1'b0}}};
    b_ext    = {b_hid, io.b_man, {GRD_W{1'b0}}};
    cmp_swap = (io.b_exp > io.a_exp) | ((io.b_exp == io.a_exp) & (io.b_man > io.a_man));
    cmp_big_man   = a_ext;
    cmp_small_man = b_ext;
    cmp_big_exp   = io.a_exp;
    cmp_diff      = a_eff - b_eff;
    if (cmp_swap) begin
      cmp_big_man   = b_ext;
      cmp_small_man = a_ext;
      cmp_big_exp   = io.b_exp;
      cmp_diff      = b_eff - a_eff;
    end
  end

  // Align stage shifter works straight off the S1 registers
  logic [W-1:0] s1_aligned;

  fp_rshift_sticky #(
    .W     (W),
    .EXP_W (EXP_W)
  ) u_rshift (
    .din   (s1_small_man),
    .shamt (s1_diff),
    .dout  (s1_aligned)
  );

  // Occupancy flags; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_fire)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv)            s2_valid <= 1'b1;
      else if (io.out_ready) s2_valid <= 1'b0;
    end
  end

  // S1 data captures the ordered operands on acceptance and otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_big_man   <= '0;
      s1_small_man <= '0;
      s1_big_exp   <= '0;
      s1_diff      <= '0;
      s1_swap      <= 1'b0;
    end else if (in_fire) begin
      s1_big_man   <= cmp_big_man;
      s1_small_man <= cmp_small_man;
      s1_big_exp   <= cmp_big_exp;
      s1_diff      <= cmp_diff;
      s1_swap      <= cmp_swap;
    end
  end

  // S2 data captures the aligned pair and stays frozen while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_big_man   <= '0;
      s2_small_man <= '0;
      s2_big_exp   <= '0;
      s2_swap      <= 1'b0;
    end else if (s1_adv) begin
      s2_big_man   <= s1_big_man;
      s2_small_man <= s1_aligned;
      s2_big_exp   <= s1_big_exp;
      s2_swap      <= s1_swap;
    end
  end

  assign io.out_valid = s2_valid;
  assign io.big_man   = s2_big_man;
  assign io.small_man = s2_small_man;
  assign io.big_exp   = s2_big_exp;
  assign io.swap      = s2_swap;

endmodule

// File: tb/tb_fp_mant_align_pipe.sv
// tb/tb_fp_mant_align_pipe.sv - directed self-checking bench for fp_mant_align_pipe
module tb_fp_mant_align_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp_mant_align_pipe_if ifc ();

  fp_mant_align_pipe dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

`ifdef FP_ALIGN_STICKY_EN
  localparam logic [26:0] EXP_T3_SMALL = 27'h0000001;
  localparam logic [26:0] EXP_ST_SMALL = 27'h0400001;
`else
  localparam logic [26:0] EXP_T3_SMALL = 27'h0000000;
  localparam logic [26:0] EXP_ST_SMALL = 27'h0400000;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ae, input logic [22:0] am,
                       input logic [7:0] be, input logic [22:0] bm);
    ifc.in_valid = 1'b1;
    ifc.a_exp = ae;
    ifc.a_man = am;
    ifc.b_exp = be;
    ifc.b_man = bm;
  endtask

  task automatic check_out(input string tag, input logic [26:0] bman, input logic [26:0] sman,
                           input logic [7:0] bexp, input logic sw);
    check({tag, ".out_valid"}, 64'(ifc.out_valid), 64'(1'b1));
    check({tag, ".big_man"},   64'(ifc.big_man),   64'(bman));
    check({tag, ".small_man"}, 64'(ifc.small_man), 64'(sman));
    check({tag, ".big_exp"},   64'(ifc.big_exp),   64'(bexp));
    check({tag, ".swap"},      64'(ifc.swap),      64'(sw));
  endtask

  task automatic run_one(input string tag,
                         input logic [7:0] ae, input logic [22:0] am,
                         input logic [7:0] be, input logic [22:0] bm,
                         input logic [26:0] bman, input logic [26:0] sman,
                         input logic [7:0] bexp, input logic sw);
    drive(ae, am, be, bm);
    #1;
    check({tag, ".in_ready"}, 64'(ifc.in_ready), 64'(1'b1));
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".lat1"}, 64'(ifc.out_valid), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    check_out(tag, bman, sman, bexp, sw);
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.a_exp = '0;
    ifc.a_man = '0;
    ifc.b_exp = '0;
    ifc.b_man = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(ifc.out_valid), 64'(1'b0));
    check("rst.big_man",   64'(ifc.big_man),   64'(27'h0));
    check("rst.small_man", 64'(ifc.small_man), 64'(27'h0));
    check("rst.big_exp",   64'(ifc.big_exp),   64'(8'h0));
    check("rst.swap",      64'(ifc.swap),      64'(1'b0));
    rst = 1'b0;
    #1;
    check("rst.in_ready", 64'(ifc.in_ready), 64'(1'b1));

    // Directed vectors
    run_one("t1",  8'd127, 23'h0, 8'd126, 23'h0,
            27'h4000000, 27'h2000000, 8'd127, 1'b0);
    run_one("t2",  8'd126, 23'h0, 8'd127, 23'h400000,
            27'h6000000, 27'h2000000, 8'd127, 1'b1);
    run_one("t3",  8'd150, 23'h0, 8'd100, 23'h1,
            27'h4000000, EXP_T3_SMALL, 8'd150, 1'b0);
    run_one("t4",  8'd1, 23'h0, 8'd0, 23'h400000,
            27'h4000000, 27'h2000000, 8'd1, 1'b0);
    run_one("stk", 8'd131, 23'h0, 8'd127, 23'h1,
            27'h4000000, EXP_ST_SMALL, 8'd131, 1'b0);
    run_one("eq",  8'd100, 23'h123456, 8'd100, 23'h123456,
            27'h491A2B0, 27'h491A2B0, 8'd100, 1'b0);
    run_one("zero", 8'd0, 23'h0, 8'd0, 23'h0,
            27'h0, 27'h0, 8'd0, 1'b0);

    // Back-pressure: fill both stages, then drain in order
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    drive(8'd127, 23'h0, 8'd126, 23'h0);
    @(negedge clk);
    check("bp.rdy1", 64'(ifc.in_ready), 64'(1'b1));
    @(posedge clk);
    #1 drive(8'd126, 23'h0, 8'd127, 23'h400000);
    @(negedge clk);
    check("bp.rdy2", 64'(ifc.in_ready), 64'(1'b1));
    @(posedge clk);
    #1 drive(8'd100, 23'h123456, 8'd100, 23'h123456);
    @(negedge clk);
    check("bp.full", 64'(ifc.in_ready), 64'(1'b0));
    check_out("bp.p1a", 27'h4000000, 27'h2000000, 8'd127, 1'b0);
    @(negedge clk);
    check("bp.full2", 64'(ifc.in_ready), 64'(1'b0));
    check_out("bp.p1b", 27'h4000000, 27'h2000000, 8'd127, 1'b0);
    ifc.out_ready = 1'b1;
    #1;
    check("bp.drain_rdy", 64'(ifc.in_ready), 64'(1'b1));
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    check_out("bp.p2", 27'h6000000, 27'h2000000, 8'd127, 1'b1);
    @(negedge clk);
    check_out("bp.p3", 27'h491A2B0, 27'h491A2B0, 8'd100, 1'b0);
    @(negedge clk);
    check("bp.empty", 64'(ifc.out_valid), 64'(1'b0));

    // Async reset with both stages occupied
    drive(8'd127, 23'h0, 8'd126, 23'h0);
    @(posedge clk);
    #1 drive(8'd126, 23'h0, 8'd127, 23'h400000);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    check("rr.pre_valid", 64'(ifc.out_valid), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("rr.out_valid", 64'(ifc.out_valid), 64'(1'b0));
    check("rr.big_man",   64'(ifc.big_man),   64'(27'h0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr.in_ready", 64'(ifc.in_ready), 64'(1'b1));
    @(negedge clk);
    check("rr.no_ghost1", 64'(ifc.out_valid), 64'(1'b0));
    @(negedge clk);
    check("rr.no_ghost2", 64'(ifc.out_valid), 64'(1'b0));
    run_one("rr.new", 8'd1, 23'h0, 8'd0, 23'h400000,
            27'h4000000, 27'h2000000, 8'd1, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
